if_id_hazard_stage: RTL and testbench

- IF/ID pipeline register of the 5-stage MIPS pipeline, merged with load-use hazard detection and taken-branch flush control.
- Sits between instruction memory / PC+4 adder (upstream) and control, register file and ID/EX (downstream).
- Drives PC write-enable, ID/EX bubble and EX/MEM flush.
- Keeps saturating stall and flush counters for debug display.

---
 rtl/if_id_hazard_stage.sv | 111 +++++++++++
 tb/tb_if_id_hazard_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection and taken-branch flush control.
// Also keeps saturating stall/flush event counters for the debug display.
module if_id_hazard_stage #(
   parameter int          COUNT_WIDTH = 16,
   parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [31:0]            pcIn,
   input  logic [31:0]            instructionIn,
   input  logic                   idExMemRead,
   input  logic [4:0]             idExRt,
   input  logic                   branchTaken,
   output logic [31:0]            outPc,
   output logic [31:0]            outInstruction,
   output logic                   outValid,
   output logic                   pcWrite,
   output logic                   bubble,
   output logic                   flushExMem,
   output logic                   stalled,
   output logic [COUNT_WIDTH-1:0] stallCount,
   output logic [COUNT_WIDTH-1:0] flushCount
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} stateT;

   stateT                  state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            instruction_q, instruction_d;
   logic                   valid_q, valid_d;
   logic [COUNT_WIDTH-1:0] stallCount_q, stallCount_d;
   logic [COUNT_WIDTH-1:0] flushCount_q, flushCount_d;

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       usesRt;
   logic       hazard;

   // Only R-type, sw and beq read rt as a source; other formats write it.
   assign op     = instruction_q[31:26];
   assign rs     = instruction_q[25:21];
   assign rt     = instruction_q[20:16];
   assign usesRt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
   assign hazard = valid_q && idExMemRead && (idExRt != 5'd0) &&
                   ((idExRt == rs) || (usesRt && (idExRt == rt)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= RUN;
         pc_q          <= 32'd0;
         instruction_q <= NOP_WORD;
         valid_q       <= 1'b0;
         stallCount_q  <= '0;
         flushCount_q  <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instruction_q <= instruction_d;
         valid_q       <= valid_d;
         stallCount_q  <= stallCount_d;
         flushCount_q  <= flushCount_d;
      end
   end

   // A branch flush wins over a stall in every state; a persisting hazard re-enters STALL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN, STALL, FLUSH: begin
            if (branchTaken)  state_d = FLUSH;
            else if (hazard)  state_d = STALL;
            else              state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_d          = pc_q;
      instruction_d = instruction_q;
      valid_d       = valid_q;
      stallCount_d  = stallCount_q;
      flushCount_d  = flushCount_q;
      if (branchTaken) begin
         pc_d          = 32'd0;
         instruction_d = NOP_WORD;
         valid_d       = 1'b0;
         if (flushCount_q != '1) flushCount_d = flushCount_q + 1'b1;
      end else if (hazard) begin
         if (stallCount_q != '1) stallCount_d = stallCount_q + 1'b1;
      end else begin
         pc_d          = pcIn;
         instruction_d = instructionIn;
         valid_d       = 1'b1;
      end
   end

   always_comb begin
      flushExMem     = branchTaken;
      pcWrite        = branchTaken || !hazard;
      bubble         = branchTaken || hazard;
      stalled        = (state_q == STALL);
      outPc          = pc_q;
      outInstruction = instruction_q;
      outValid       = valid_q;
      stallCount     = stallCount_q;
      flushCount     = flushCount_q;
   end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Self-checking bench for if_id_hazard_stage: directed scenarios followed by random
// traffic, all compared against a rule-level reference model kept in the bench.
module tb_if_id_hazard_stage;

   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   pcIn, instructionIn;
   logic          idExMemRead;
   logic [4:0]    idExRt;
   logic          branchTaken;
   logic [31:0]   outPc, outInstruction;
   logic          outValid, pcWrite, bubble, flushExMem, stalled;
   logic [CW-1:0] stallCount, flushCount;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mPc, mInstr;
   logic        mValid, mStalled;
   int          mStallCnt, mFlushCnt;

   if_id_hazard_stage #(.COUNT_WIDTH(CW), .NOP_WORD(32'h0)) dut (
      .clock(clock), .reset(reset), .pcIn(pcIn), .instructionIn(instructionIn),
      .idExMemRead(idExMemRead), .idExRt(idExRt), .branchTaken(branchTaken),
      .outPc(outPc), .outInstruction(outInstruction), .outValid(outValid),
      .pcWrite(pcWrite), .bubble(bubble), .flushExMem(flushExMem), .stalled(stalled),
      .stallCount(stallCount), .flushCount(flushCount)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Load-use rule evaluated directly on the instruction held in ID.
   function automatic bit modelHazard(input logic [31:0] instr, input bit valid, input bit memRead, input int exRt);
      int  opcode, srcS, srcT;
      bit  readsT;
      opcode = int'(instr[31:26]);
      srcS   = int'(instr[25:21]);
      srcT   = int'(instr[20:16]);
      readsT = (opcode == 0) || (opcode == 'h2B) || (opcode == 4);
      return valid && memRead && exRt != 0 && (exRt == srcS || (readsT && exRt == srcT));
   endfunction

   function automatic int satInc(input int c);
      return (c >= MAXC) ? MAXC : c + 1;
   endfunction

   task automatic applyStimulus(input bit rst, input logic [31:0] pc, input logic [31:0] instr,
                                input bit memRead, input logic [4:0] exRt, input bit br);
      bit hz;
      @(negedge clock);
      reset = rst; pcIn = pc; instructionIn = instr;
      idExMemRead = memRead; idExRt = exRt; branchTaken = br;
      #1;
      hz = modelHazard(mInstr, mValid, memRead, int'(exRt));
      if (!rst) begin
         checkOutput("flushExMem", 32'(flushExMem), 32'(br));
         checkOutput("pcWrite", 32'(pcWrite), 32'(br || !hz));
         checkOutput("bubble", 32'(bubble), 32'(br || hz));
      end
      @(posedge clock);
      if (rst) begin
         mPc = 0; mInstr = 32'h0; mValid = 0; mStalled = 0; mStallCnt = 0; mFlushCnt = 0;
      end else if (br) begin
         mPc = 0; mInstr = 32'h0; mValid = 0; mStalled = 0; mFlushCnt = satInc(mFlushCnt);
      end else if (hz) begin
         mStalled = 1; mStallCnt = satInc(mStallCnt);
      end else begin
         mPc = pc; mInstr = instr; mValid = 1; mStalled = 0;
      end
      #1;
      checkOutput("outPc", outPc, mPc);
      checkOutput("outInstruction", outInstruction, mInstr);
      checkOutput("outValid", 32'(outValid), 32'(mValid));
      checkOutput("stalled", 32'(stalled), 32'(mStalled));
      checkOutput("stallCount", 32'(stallCount), 32'(mStallCnt));
      checkOutput("flushCount", 32'(flushCount), 32'(mFlushCnt));
   endtask

   function automatic logic [31:0] randomInstr();
      logic [5:0] ops [5] = '{6'h00, 6'h2B, 6'h04, 6'h08, 6'h23};
      logic [31:0] w;
      w = $urandom;
      w[31:26] = ops[$urandom_range(4)];
      w[25:21] = 5'($urandom_range(3));
      w[20:16] = 5'($urandom_range(3));
      return w;
   endfunction

   initial begin
      mPc = 0; mInstr = 0; mValid = 0; mStalled = 0; mStallCnt = 0; mFlushCnt = 0;
      reset = 1; pcIn = 0; instructionIn = 0; idExMemRead = 0; idExRt = 0; branchTaken = 0;

      // Reset held two cycles with a live instruction on the bus
      applyStimulus(1, 32'h40, 32'h8C080004, 0, 0, 0);
      applyStimulus(1, 32'h40, 32'h8C080004, 0, 0, 0);
      checkOutput("resetInstr", outInstruction, 32'h0);
      checkOutput("resetPcWrite", 32'(pcWrite), 32'd1);
      checkOutput("resetBubble", 32'(bubble), 32'd0);

      // Straight-line flow
      applyStimulus(0, 32'd4, 32'h01095020, 0, 0, 0);
      applyStimulus(0, 32'd8, 32'h01095020, 0, 0, 0);
      checkOutput("straightPc", outPc, 32'd8);

      // Load-use on rs of add, then release
      applyStimulus(0, 32'd12, 32'h11111111, 1, 5'd8, 0);
      checkOutput("loadUseHold", outInstruction, 32'h01095020);
      checkOutput("loadUseStallCnt", 32'(stallCount), 32'd1);
      applyStimulus(0, 32'd12, 32'h21280005, 0, 0, 0);
      checkOutput("releaseLoad", outInstruction, 32'h21280005);

      // addi writes rt: idExRt matching rt or $0 is not a hazard
      applyStimulus(0, 32'd16, 32'h22222222, 1, 5'd8, 0);
      applyStimulus(0, 32'd20, 32'h21280005, 0, 0, 0);
      applyStimulus(0, 32'd24, 32'h01095020, 1, 5'd0, 0);

      // Branch flush, then again with a concurrent hazard (add in ID, rs=8)
      applyStimulus(0, 32'd28, 32'hAAAAAAAA, 0, 0, 1);
      applyStimulus(0, 32'd32, 32'h01095020, 0, 0, 0);
      applyStimulus(0, 32'd36, 32'hBBBBBBBB, 1, 5'd8, 1);
      checkOutput("flushNoStall", 32'(stallCount), 32'd1);

      // Four consecutive stalls saturate the 2-bit counter, then reset mid-stall
      applyStimulus(0, 32'd40, 32'h01095020, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 32'd44, 32'hCCCCCCCC, 1, 5'd9, 0);
      checkOutput("stallSat", 32'(stallCount), 32'd3);
      applyStimulus(1, 32'd48, 32'hDDDDDDDD, 1, 5'd9, 0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         applyStimulus($urandom_range(99) < 3, $urandom, randomInstr(), $urandom_range(1),
                       5'($urandom_range(3)), $urandom_range(99) < 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
